// File: rtl/c_hazard_idex_pkg.sv
// Shared pipeline types for the ID/EX hazard unit.
// Forwarding encodings, timing widths and the ID/EX control bundle.
package c_hazard_idex_pkg;

  localparam int TW = 3;
  localparam int RW = 5;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_E  = 2'd1,
    FWD_M  = 2'd2,
    FWD_W  = 2'd3
  } fwd_sel_e;

  typedef struct packed {
    logic          regw;
    logic          memtoreg;
    logic          jjal;
    logic [RW-1:0] a3;
    logic [TW-1:0] t_new;
  } id_ex_t;

  localparam id_ex_t ID_EX_BUBBLE = '0;

  function automatic logic produces(
    input logic          regw,
    input logic [RW-1:0] a3,
    input logic [RW-1:0] r
  );
    return regw && (a3 == r) && (r != '0);
  endfunction

endpackage

// File: rtl/c_hazard_idex_cmp.sv
// Per-operand hazard check: stall request and forwarding source.
// The nearest producer of the register decides both results.
module c_hazard_cmp
  import c_hazard_idex_pkg::*;
(
  input  logic [RW-1:0] r,
  input  logic [TW-1:0] t_use,
  input  logic          regw_e,
  input  logic [RW-1:0] a3_e,
  input  logic [TW-1:0] t_new_e,
  input  logic          regw_m,
  input  logic [RW-1:0] a3_m,
  input  logic [TW-1:0] t_new_m,
  input  logic          regw_w,
  input  logic [RW-1:0] a3_w,
  output logic          stall_req,
  output logic [1:0]    fwd_sel
);

  logic hit_e;
  logic hit_m;
  logic hit_w;

  assign hit_e = produces(regw_e, a3_e, r);
  assign hit_m = produces(regw_m, a3_m, r);
  assign hit_w = produces(regw_w, a3_w, r);

  // A match in E shadows any older value of the same register in M.
  always_comb begin
    stall_req = 1'b0;
    if (hit_e)
      stall_req = (t_new_e > t_use);
    else if (hit_m)
      stall_req = (t_new_m > t_use);
  end

  always_comb begin
    fwd_sel = FWD_RF;
    if (hit_e && t_new_e == '0)
      fwd_sel = FWD_E;
    else if (hit_m && t_new_m == '0)
      fwd_sel = FWD_M;
    else if (hit_w)
      fwd_sel = FWD_W;
  end

endmodule

// File: rtl/c_hazard_idex.sv
// ID/EX hazard unit: stall, forwarding selects and the E control register.
// Define STALL_CNT_EN to add the 32-bit stall_cnt output.
module c_hazard_idex
  import c_hazard_idex_pkg::*;
(
  input  logic          clk,
  input  logic          clr_n,
  input  logic [RW-1:0] rsD,
  input  logic [RW-1:0] rtD,
  input  logic [TW-1:0] t_use_rsD,
  input  logic [TW-1:0] t_use_rtD,
  input  logic          regwD,
  input  logic          memtoregD,
  input  logic          jjalD,
  input  logic [RW-1:0] a3D,
  input  logic [TW-1:0] T_new_D,
  input  logic          regwM,
  input  logic [RW-1:0] a3M,
  input  logic [TW-1:0] T_new_M,
  input  logic          regwW,
  input  logic [RW-1:0] a3W,
  input  logic          flushE,
  output logic          stall,
  output logic          regwE,
  output logic          memtoregE,
  output logic          jjalE,
  output logic [RW-1:0] a3E,
  output logic [TW-1:0] T_new_E,
  output logic [1:0]    fwd_rs_sel,
  output logic [1:0]    fwd_rt_sel
`ifdef STALL_CNT_EN
  ,
  output logic [31:0]   stall_cnt
`endif
);

  id_ex_t e_q;
  id_ex_t d;
  logic   stall_rs;
  logic   stall_rt;

  assign d = '{regw:     regwD,
               memtoreg: memtoregD,
               jjal:     jjalD,
               a3:       a3D,
               t_new:    T_new_D};

  c_hazard_cmp u_cmp_rs (
    .r         (rsD),
    .t_use     (t_use_rsD),
    .regw_e    (e_q.regw),
    .a3_e      (e_q.a3),
    .t_new_e   (e_q.t_new),
    .regw_m    (regwM),
    .a3_m      (a3M),
    .t_new_m   (T_new_M),
    .regw_w    (regwW),
    .a3_w      (a3W),
    .stall_req (stall_rs),
    .fwd_sel   (fwd_rs_sel)
  );

  c_hazard_cmp u_cmp_rt (
    .r         (rtD),
    .t_use     (t_use_rtD),
    .regw_e    (e_q.regw),
    .a3_e      (e_q.a3),
    .t_new_e   (e_q.t_new),
    .regw_m    (regwM),
    .a3_m      (a3M),
    .t_new_m   (T_new_M),
    .regw_w    (regwW),
    .a3_w      (a3W),
    .stall_req (stall_rt),
    .fwd_sel   (fwd_rt_sel)
  );

  assign stall = stall_rs | stall_rt;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)
      e_q <= ID_EX_BUBBLE;
    else if (stall || flushE)
      e_q <= ID_EX_BUBBLE;
    else
      e_q <= d;
  end

  assign regwE     = e_q.regw;
  assign memtoregE = e_q.memtoreg;
  assign jjalE     = e_q.jjal;
  assign a3E       = e_q.a3;
  assign T_new_E   = e_q.t_new;

`ifdef STALL_CNT_EN
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)
      stall_cnt <= '0;
    else if (stall)
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_c_hazard_idex.sv
// Self-checking bench for c_hazard_idex: directed cases plus
// randomized traffic against a behavioural hazard model.
module tb_c_hazard_idex;

  logic       clk = 1'b0;
  logic       clr_n;
  logic [4:0] rsD, rtD, a3D, a3M, a3W;
  logic [2:0] t_use_rsD, t_use_rtD, T_new_D, T_new_M;
  logic       regwD, memtoregD, jjalD, regwM, regwW, flushE;
  logic       stall, regwE, memtoregE, jjalE;
  logic [4:0] a3E;
  logic [2:0] T_new_E;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;
`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;

  // model of the E stage and the stall counter
  int m_regw, m_mtr, m_jjal, m_a3, m_tn;
  int m_cnt;

  always #5 clk = ~clk;

  c_hazard_idex dut (
    .clk(clk), .clr_n(clr_n),
    .rsD(rsD), .rtD(rtD),
    .t_use_rsD(t_use_rsD), .t_use_rtD(t_use_rtD),
    .regwD(regwD), .memtoregD(memtoregD), .jjalD(jjalD),
    .a3D(a3D), .T_new_D(T_new_D),
    .regwM(regwM), .a3M(a3M), .T_new_M(T_new_M),
    .regwW(regwW), .a3W(a3W),
    .flushE(flushE),
    .stall(stall),
    .regwE(regwE), .memtoregE(memtoregE), .jjalE(jjalE),
    .a3E(a3E), .T_new_E(T_new_E),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel)
`ifdef STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit writes(int w, int a, int r);
    return (w != 0) && (a == r) && (r != 0);
  endfunction

  // A register written by several in-flight instructions takes its
  // value from the youngest one.
  function automatic bit m_stall_op(int r, int tu);
    if (writes(m_regw, a3E_m(), r)) return m_tn > tu;
    if (writes(regwM, a3M, r)) return int'(T_new_M) > tu;
    return 0;
  endfunction

  function automatic int a3E_m();
    return m_a3;
  endfunction

  function automatic int m_fwd(int r);
    if (writes(m_regw, m_a3, r) && m_tn == 0) return 1;
    if (writes(regwM, a3M, r) && T_new_M == 0) return 2;
    if (writes(regwW, a3W, r)) return 3;
    return 0;
  endfunction

  function automatic bit m_stall();
    return m_stall_op(rsD, t_use_rsD) || m_stall_op(rtD, t_use_rtD);
  endfunction

  function automatic logic [10:0] m_e();
    return {m_regw[0], m_mtr[0], m_jjal[0], m_a3[4:0], m_tn[2:0]};
  endfunction

  task automatic m_clear();
    m_regw = 0; m_mtr = 0; m_jjal = 0; m_a3 = 0; m_tn = 0;
  endtask

  task automatic clr_inputs();
    rsD = 0; rtD = 0; t_use_rsD = 0; t_use_rtD = 0;
    regwD = 0; memtoregD = 0; jjalD = 0; a3D = 0; T_new_D = 0;
    regwM = 0; a3M = 0; T_new_M = 0; regwW = 0; a3W = 0;
    flushE = 0;
  endtask

  // Advance one edge, updating the model from the inputs present before it.
  task automatic step();
    bit s;
    s = m_stall();
    @(posedge clk);
    if (clr_n) begin
      if (s) m_cnt++;
      if (s || flushE) m_clear();
      else begin
        m_regw = regwD; m_mtr = memtoregD; m_jjal = jjalD;
        m_a3 = a3D; m_tn = T_new_D;
      end
    end
    #1;
  endtask

  function automatic logic [10:0] dut_e();
    return {regwE, memtoregE, jjalE, a3E, T_new_E};
  endfunction

  task automatic load_e(int w, int a, int t);
    clr_inputs();
    regwD = w[0]; a3D = a[4:0]; T_new_D = t[2:0];
    step();
    clr_inputs();
  endtask

  initial begin
    clr_n = 0;
    clr_inputs();
    m_clear();
    m_cnt = 0;
    #12;
    chk("rst_e", 32'(dut_e()), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_fwd", {fwd_rs_sel, fwd_rt_sel}, 32'd0);
`ifdef STALL_CNT_EN
    chk("rst_cnt", stall_cnt, 32'd0);
`endif
    clr_n = 1;
    @(posedge clk); #1;

    // load-use: lw in E, dependent add in D
    load_e(1, 8, 2);
    chk("lu_e", 32'(dut_e()), 32'(m_e()));
    rsD = 8; t_use_rsD = 1;
    #1 chk("lu_stall", 32'(stall), 32'd1);
    regwD = 1; a3D = 10; T_new_D = 1;
    step();
    chk("lu_bubble", 32'(dut_e()), 32'd0);
    regwM = 1; a3M = 8; T_new_M = 1;
    #1 chk("lu_stall2", 32'(stall), 32'd0);
    chk("lu_fwd_rf", 32'(fwd_rs_sel), 32'd0);
    step();
    regwM = 0; a3M = 0; T_new_M = 0;
    regwW = 1; a3W = 8;
    #1 chk("lu_fwd_w", 32'(fwd_rs_sel), 32'd3);
    clr_inputs();
    step();

    // branch right after an ALU op
    load_e(1, 9, 1);
    rtD = 9; t_use_rtD = 0;
    #1 chk("br_stall", 32'(stall), 32'd1);
    step();
    regwM = 1; a3M = 9; T_new_M = 0;
    #1 chk("br_stall2", 32'(stall), 32'd0);
    chk("br_fwd_m", 32'(fwd_rt_sel), 32'd2);
    clr_inputs();

    // producer priority and register zero
    load_e(1, 5, 0);
    regwM = 1; a3M = 5; T_new_M = 0;
    regwW = 1; a3W = 5; rsD = 5;
    #1 chk("pri_fwd_e", 32'(fwd_rs_sel), 32'd1);
    clr_inputs();
    load_e(1, 0, 0);
    regwM = 1; regwW = 1; rsD = 0; t_use_rsD = 0;
    #1 chk("r0_fwd", 32'(fwd_rs_sel), 32'd0);
    chk("r0_stall", 32'(stall), 32'd0);
    clr_inputs();

    // flush together with stall, then flush alone
    load_e(1, 6, 2);
    rsD = 6; t_use_rsD = 0; flushE = 1;
    regwD = 1; a3D = 7; T_new_D = 1;
    step();
    chk("fl_st_e", 32'(dut_e()), 32'd0);
    clr_inputs();
    regwD = 1; a3D = 3; T_new_D = 2; memtoregD = 1; flushE = 1;
    step();
    chk("fl_e", 32'(dut_e()), 32'd0);
    clr_inputs();

    // asynchronous reset between edges
    load_e(1, 4, 2);
    chk("pre_rst_e", 32'(dut_e()), 32'(m_e()));
    #2 clr_n = 0;
    #1 chk("mid_rst_e", 32'(dut_e()), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    m_clear();
`ifdef STALL_CNT_EN
    chk("mid_rst_cnt", stall_cnt, 32'd0);
`endif
    m_cnt = 0;
    #1 clr_n = 1;
    // instruction present at release enters E normally
    regwD = 1; a3D = 12; T_new_D = 1; jjalD = 1;
    step();
    chk("rel_e", 32'(dut_e()), 32'(m_e()));
    clr_inputs();

    // three forced stall cycles
    load_e(1, 2, 3);
    rsD = 2; t_use_rsD = 0; regwM = 1; a3M = 2; T_new_M = 2;
    step(); step(); step();
`ifdef STALL_CNT_EN
    chk("cnt3", stall_cnt, 32'(m_cnt));
`endif
    clr_inputs();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rsD = 5'($urandom_range(0, 3));
      rtD = 5'($urandom_range(0, 3));
      t_use_rsD = 3'($urandom_range(0, 3));
      t_use_rtD = 3'($urandom_range(0, 3));
      regwD = 1'($urandom);
      memtoregD = 1'($urandom);
      jjalD = 1'($urandom);
      a3D = 5'($urandom_range(0, 3));
      T_new_D = 3'($urandom_range(0, 3));
      regwM = 1'($urandom);
      a3M = 5'($urandom_range(0, 3));
      T_new_M = 3'($urandom_range(0, 2));
      regwW = 1'($urandom);
      a3W = 5'($urandom_range(0, 3));
      flushE = ($urandom_range(0, 7) == 0);
      #1;
      chk("rnd_stall", 32'(stall), 32'(m_stall()));
      chk("rnd_fwd_rs", 32'(fwd_rs_sel), 32'(m_fwd(rsD)));
      chk("rnd_fwd_rt", 32'(fwd_rt_sel), 32'(m_fwd(rtD)));
      step();
      chk("rnd_e", 32'(dut_e()), 32'(m_e()));
    end
`ifdef STALL_CNT_EN
    chk("rnd_cnt", stall_cnt, 32'(m_cnt));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/c_hazard_idex.md
C_HAZARD_IDEX -- requirements
Module: c_hazard_idex

Interface
REQ-001 SHALL have ports: clk input 1 (pipeline clock, rising edge); clr_n input 1 (async active-low reset).
REQ-002 SHALL have D-stage inputs: rsD/rtD input 5 (source regs); t_use_rsD/t_use_rtD input 3 (cycles until operand needed); regwD, memtoregD, jjalD input 1 (decoded control); a3D input 5 (dest reg); T_new_D input 3 (cycles until result ready, counted from E entry).
REQ-003 SHALL have downstream-stage inputs: regwM input 1, a3M input 5, T_new_M input 3 (from EX/MEM); regwW input 1, a3W input 5 (from MEM/WB).
REQ-004 SHALL have flushE input 1 (request bubble into E).
REQ-005 SHALL have outputs: stall output 1 (freeze PC and IF/ID); regwE, memtoregE, jjalE output 1; a3E output 5; T_new_E output 3; fwd_rs_sel/fwd_rt_sel output 2 (0=regfile, 1=E, 2=M, 3=W).

Function
REQ-006 SHALL treat a stage X as producing register r when regwX=1, a3X==r and r!=0.
REQ-007 SHALL assert stall combinationally when, for rsD or rtD, E produces it with T_new_E > t_use, or M produces it with T_new_M > t_use; W never causes stall.
REQ-008 SHALL evaluate E before M for the same register; a stall from either operand stalls.
REQ-009 SHALL drive fwd_*_sel combinationally to the nearest producing stage whose T_new is 0 (E over M over W), else 0; reg 0 always selects 0.
REQ-010 SHALL, on each rising clk edge with stall=0 and flushE=0, load regwE, memtoregE, jjalE, a3E, T_new_E from D inputs unmodified (one-cycle latency).
REQ-011 SHALL, on a rising edge with stall=1 or flushE=1, load a bubble: all E outputs 0.
REQ-012 SHALL treat simultaneous stall and flushE as a single bubble, no extra state.
REQ-013 SHALL not decrement T_new at this boundary; decrement occurs at E/M and M/W boundaries, saturating at 0.
REQ-014 SHALL keep stall purely combinational; no stall-history state.

Reset
REQ-015 SHALL, while clr_n=0, asynchronously force regwE, memtoregE, jjalE, a3E, T_new_E to 0.
REQ-016 SHALL, after reset deasserts mid-stream, resume normal loading at the next rising edge; an instruction in D at reset release enters E normally.
REQ-017 SHALL produce stall=0 and fwd selects=0 during reset (E stage is a bubble, inputs from M/W are the cleared values of their registers).

Configuration
REQ-018 SHALL, when STALL_CNT_EN is defined, add output stall_cnt 32 bits, reset to 0, incremented on each rising edge where stall=1 and clr_n=1, wrapping from 0xFFFFFFFF to 0.
REQ-019 SHALL, when STALL_CNT_EN is undefined, omit the stall_cnt port and counter; all other behaviour identical.

Structure
REQ-020 SHALL place fwd_sel encodings (FWD_RF=0, FWD_E=1, FWD_M=2, FWD_W=3) and T_new/t_use width constant (3) in the shared pipeline package.
REQ-021 SHALL contain one sub-module, c_hazard_cmp, instantiated once per source operand (rs, rt): inputs register plus E/M/W producer info, outputs stall_req and fwd_sel.
REQ-022 SHALL hold the E-stage control register in the top module.

Verification
REQ-023 Load-use: lw in E (regwE=1, a3E=8, T_new_E=2), D add with rsD=8, t_use_rsD=1 -> stall=1, E bubble next edge; next cycle T_new_M=1 -> stall=0, fwd_rs_sel=0; following cycle fwd_rs_sel=3 (W).
REQ-024 Branch after ALU: E add a3E=9, T_new_E=1; D beq rtD=9, t_use_rtD=0 -> stall=1 one cycle; then M match T_new_M=0 -> stall=0, fwd_rt_sel=2.
REQ-025 Priority: E, M, W all write reg 5 with T_new=0, rsD=5 -> fwd_rs_sel=1; rsD=0 with all writing reg 0 -> fwd_rs_sel=0, stall=0.
REQ-026 Flush+stall: flushE=1 and stall=1 same edge -> E outputs all 0 next cycle; flushE=1 alone with regwD=1, a3D=3 -> E outputs 0.
REQ-027 Reset mid-operation: E holds regwE=1, a3E=4, T_new_E=2; pulse clr_n low between edges -> outputs 0 immediately; stall_cnt=0 when STALL_CNT_EN defined.
REQ-028 Counter: STALL_CNT_EN defined, force 3 stall cycles -> stall_cnt=3; preload path near 0xFFFFFFFF -> wraps to 0.
